// File: rtl/uart_prog_loader.sv
// UART program loader: parses a length-prefixed byte stream, writes little-endian words to instruction memory
// from address 0, and answers ACK/NAK. Define LOADER_CSUM_EN to expect and check a trailing checksum byte.
module uart_prog_loader #(
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              prog,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_RESP, S_WAITLOW
    } state_t;

    localparam int            TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYC);
    localparam logic [16:0]   DEPTH = 17'(2 ** ADDR_W);
    localparam logic [7:0]    ACK   = 8'h06;
    localparam logic [7:0]    NAK   = 8'h15;
`ifdef LOADER_CSUM_EN
    localparam state_t AFTER_DATA = S_CSUM;
`else
    localparam state_t AFTER_DATA = S_RESP;
`endif

    state_t              state_q, state_d;
    logic                prog_q, prog_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          bidx_q, bidx_d;
    logic [31:0]         word_q, word_d;
    logic [TW-1:0]       idle_q, idle_d;
    logic                err_q, err_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                done_q, done_d;
    logic                mem_we_q, mem_we_d;
    logic                core_hold_q, core_hold_d;
    logic                timed;
    logic [15:0]         n_full;
`ifdef LOADER_CSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    always_comb begin
        state_d    = state_q;
        prog_d     = prog;
        len_d      = len_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        bidx_d     = bidx_q;
        word_d     = word_q;
        err_d      = err_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;
        n_full     = {rx_data, len_q[7:0]};
`ifdef LOADER_CSUM_EN
        csum_d     = csum_q;
`endif
        timed = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                (state_q == S_DATA) || (state_q == S_CSUM);
        // Idle counter only runs while waiting for a byte, and saturates.
        if (!timed || rx_valid) begin
            idle_d = '0;
        end else if (idle_q < TMAX) begin
            idle_d = idle_q + TW'(1);
        end else begin
            idle_d = idle_q;
        end

        case (state_q)
            S_IDLE: begin
                if (prog && !prog_q) begin
                    state_d = S_LEN0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    addr_d  = '0;
                    bidx_d  = '0;
                    idle_d  = '0;
`ifdef LOADER_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN0: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    if (n_full == 16'd0) begin
                        state_d = AFTER_DATA;
                    end else if ({1'b0, n_full} > DEPTH) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    word_d = {rx_data, word_q[31:8]};
                    bidx_d = bidx_q + 2'd1;
`ifdef LOADER_CSUM_EN
                    csum_d = csum_q + rx_data;
`endif
                    if (bidx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // A byte arriving here is an overrun: dropped, flagged, NAK once the write lands.
                if (rx_valid) begin
                    err_d = 1'b1;
                end
                if (mem_ready) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + 16'd1;
                    if (err_q || rx_valid) begin
                        state_d = S_RESP;
                    end else if (cnt_q + 16'd1 == len_q) begin
                        state_d = AFTER_DATA;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
`ifdef LOADER_CSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end
`endif
            S_RESP: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = err_q ? NAK : ACK;
                    done_d     = !err_q;
                    state_d    = S_WAITLOW;
                end
            end
            S_WAITLOW: begin
                if (!prog) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timed && idle_q >= TMAX) begin
            err_d   = 1'b1;
            state_d = S_RESP;
        end

        // Losing prog mid-load beats everything, including a write accepted this cycle.
        if (state_q != S_IDLE && state_q != S_WAITLOW && !prog) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            addr_d     = addr_q;
            cnt_d      = cnt_q;
            tx_start_d = 1'b0;
            tx_data_d  = tx_data_q;
            done_d     = 1'b0;
        end

        mem_we_d    = (state_d == S_WRITE);
        core_hold_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            prog_q      <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            bidx_q      <= '0;
            word_q      <= '0;
            idle_q      <= '0;
            err_q       <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            core_hold_q <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prog_q      <= prog_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            bidx_q      <= bidx_d;
            word_q      <= word_d;
            idle_q      <= idle_d;
            err_q       <= err_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            done_q      <= done_d;
            mem_we_q    <= mem_we_d;
            core_hold_q <= core_hold_d;
`ifdef LOADER_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign core_hold = core_hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: a stream-level model predicts memory writes and the response byte.
module tb_uart_prog_loader;
    localparam int ADDR_W = 12;
    localparam int TO     = 50;
`ifdef LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              Rst, prog, rx_valid, tx_busy, mem_ready;
    logic [7:0]        rx_data;
    logic              tx_start, mem_we, core_hold, done, err;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [8:0]         resp_q[$];
    logic [7:0]         stream[$];

    uart_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .Rst(Rst), .prog(prog), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .core_hold(core_hold), .done(done), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: words are little-endian groups of four stream bytes, written to addresses 0,1,2...
    function automatic logic [31:0] word_of(input int i);
        return {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
    endfunction

    function automatic logic [7:0] sum_of();
        logic [7:0] s = 8'h00;
        foreach (stream[i]) s = s + stream[i];
        return s;
    endfunction

    task automatic expect_writes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({ADDR_W'(i), word_of(i)});
    endtask

    task automatic expect_resp(input bit ack);
        resp_q.push_back({ack, ack ? 8'h06 : 8'h15});
    endtask

    // Scoreboard: every accepted write and every response launch is checked against the model.
    always @(negedge clk) begin
        if (!Rst) begin
            if (mem_we && mem_ready && prog) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL write_unexpected: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
                end else begin
                    check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
                end
            end
            if (tx_start) begin
                if (resp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_unexpected: got tx %0h expected no response", tx_data);
                end else begin
                    check("resp", {done, tx_data}, resp_q.pop_front());
                end
            end
            if (done && !tx_start) begin
                checks++; failures++;
                $display("FAIL done_alone: got done=1 expected done only with tx_start");
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        while (mem_we && k < 200) begin
            tick(1);
            k++;
        end
        if (k >= 200) check("write_stuck", 1, 0);
        tick(2);
        send_raw(b);
    endtask

    task automatic send_len(input logic [15:0] n);
        send(n[7:0]);
        send(n[15:8]);
    endtask

    task automatic wait_tx(input int limit, output int cyc);
        bit found = 1'b0;
        cyc = 0;
        while (!found && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (tx_start) found = 1'b1;
        end
        if (!found) check("tx_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic start_prog();
        prog = 1'b1;
        tick(2);
        check("hold_on_start", core_hold, 1);
        check("err_cleared", err, 0);
    endtask

    task automatic end_prog();
        prog = 1'b0;
        tick(2);
        check("hold_released", core_hold, 0);
        check("idle_state", dbg_state, 0);
    endtask

    task automatic run_full(input logic [7:0] csum);
        logic [7:0] bytes[$];
        int nw = stream.size() / 4;
        int c;
        int seen = 0;
        bit ack = CSUM_EN ? (csum == sum_of()) : 1'b1;
        bytes = stream;
        if (CSUM_EN) bytes.push_back(csum);
        start_prog();
        expect_writes(nw);
        expect_resp(ack);
        send_len(16'(nw));
        for (int i = 0; i < bytes.size() - 1; i++) send(bytes[i]);
        tx_busy = 1'b1;
        send(bytes[bytes.size()-1]);
        repeat (6) begin
            @(negedge clk);
            if (tx_start) seen++;
        end
        @(posedge clk);
        #1;
        check("busy_hold", seen, 0);
        tx_busy = 1'b0;
        wait_tx(50, c);
        check("err_after_load", err, !ack);
        check("writes_done", exp_q.size(), 0);
        check("hold_in_waitlow", core_hold, 1);
        end_prog();
    endtask

    initial begin
        int c;
        int bad;
        Rst = 1'b1; prog = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tx_busy = 1'b0; mem_ready = 1'b1;
        tick(3);
        check("reset_outputs", {tx_start, tx_data, mem_we, mem_addr, mem_wdata, core_hold, done, err, dbg_state}, 0);
        Rst = 1'b0;
        tick(2);

        // Basic load, good checksum; pin the model with hand-computed values.
        stream = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h02, 8'h00, 8'h00};
        check("model_w0", word_of(0), 32'h00000013);
        check("model_w1", word_of(1), 32'h000002B7);
        check("model_sum", sum_of(), 8'hCC);
        run_full(8'hCC);

        // Same stream, wrong checksum.
        run_full(8'h00);

        // Memory stalls the first write for 20 cycles.
        stream = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
        check("model_stall_w0", word_of(0), 32'hDEADBEEF);
        start_prog();
        expect_writes(2);
        expect_resp(1'b1);
        send_len(16'd2);
        for (int i = 0; i < 3; i++) send(stream[i]);
        mem_ready = 1'b0;
        send(stream[3]);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!(mem_we === 1'b1 && mem_addr === '0 && mem_wdata === 32'hDEADBEEF)) bad++;
        end
        check("stall_stable", bad, 0);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(stream[i]);
        if (CSUM_EN) send(sum_of());
        wait_tx(50, c);
        check("stall_err", err, 0);
        end_prog();

        // Length one word beyond memory depth.
        stream = {};
        start_prog();
        expect_resp(1'b0);
        send_len(16'h1001);
        wait_tx(50, c);
        check("len_err", err, 1);
        tick(10);
        check("len_hold", core_hold, 1);
        check("len_no_write", exp_q.size(), 0);
        end_prog();

        // Zero-length load.
        start_prog();
        expect_resp(1'b1);
        send_len(16'h0000);
        if (CSUM_EN) send(8'h00);
        wait_tx(50, c);
        check("zero_err", err, 0);
        end_prog();

        // Stream stalls after three data bytes: timeout NAK.
        start_prog();
        expect_resp(1'b0);
        send_len(16'd2);
        send(8'h11); send(8'h22); send(8'h33);
        wait_tx(80, c);
        check("timeout_window", (c >= TO && c <= TO + 6), 1);
        check("timeout_err", err, 1);
        end_prog();

        // prog dropped mid-DATA: abort, no response.
        start_prog();
        send_len(16'd2);
        send(8'h11); send(8'h22);
        prog = 1'b0;
        tick(2);
        check("abort_hold", core_hold, 0);
        check("abort_err", err, 1);
        check("abort_we", mem_we, 0);
        tick(20);
        check("abort_state", dbg_state, 0);

        // Overrun: byte arrives while the write is pending.
        stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        start_prog();
        expect_writes(1);
        expect_resp(1'b0);
        send_len(16'd1);
        for (int i = 0; i < 3; i++) send(stream[i]);
        mem_ready = 1'b0;
        send(stream[3]);
        send_raw(8'h55);
        tick(2);
        mem_ready = 1'b1;
        wait_tx(50, c);
        check("overrun_err", err, 1);
        check("overrun_write", exp_q.size(), 0);
        end_prog();

        // Reset during a stalled write, then a clean load from address 0.
        start_prog();
        send_len(16'd1);
        for (int i = 0; i < 3; i++) send(stream[i]);
        mem_ready = 1'b0;
        send(stream[3]);
        check("pre_reset_we", mem_we, 1);
        Rst = 1'b1;
        #1;
        check("async_reset", {tx_start, tx_data, mem_we, mem_addr, mem_wdata, core_hold, done, err, dbg_state}, 0);
        @(posedge clk);
        #1;
        prog = 1'b0;
        mem_ready = 1'b1;
        Rst = 1'b0;
        tick(2);
        stream = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h02, 8'h00, 8'h00};
        run_full(8'hCC);

        check("resp_drained", resp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Program-load controller between the UART receiver/transmitter and the instruction memory write port of the mini RISC-V top. While `prog` is high it holds the core in reset, parses a length-prefixed byte stream from the UART, assembles little-endian 32-bit words, writes them to consecutive instruction-memory addresses from 0, and returns a one-byte ACK/NAK. It arbitrates instruction-memory write ownership: the loader owns it whenever `core_hold` is high.

## Interface
- `ADDR_W`, 12: instruction-memory word-address width; depth = 2^ADDR_W words.
- `TIMEOUT_CYC`, 100000: idle cycles allowed between received bytes before abort.
- `clk`  in  1  system clock.
- `Rst`  in  1  asynchronous, active-high reset.
- `prog`  in  1  program-mode request, level.
- `rx_data`  in  8  received byte, valid with `rx_valid`.
- `rx_valid`  in  1  one-cycle pulse per received byte.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_start`  out  1  one-cycle pulse launching `tx_data`.
- `tx_data`  out  8  response byte: 0x06 ACK, 0x15 NAK.
- `mem_we`  out  1  instruction-memory write request.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  write data.
- `mem_ready`  in  1  memory accepts write in the cycle it is high with `mem_we`.
- `core_hold`  out  1  holds core in reset; high in every state except IDLE.
- `done`  out  1  one-cycle pulse when ACK is launched.
- `err`  out  1  sticky error; cleared on `prog` rising edge.

## Operation
- States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, RESP, WAITLOW.
- IDLE: on `prog` rising edge → LEN0; clear `err`, byte counter, address, checksum.
- LEN0/LEN1: capture N[7:0] then N[15:8]. After LEN1: N = 0 → CSUM; N > 2^ADDR_W → set `err`, RESP(NAK); else → DATA.
- DATA: shift bytes into word, byte 0 → bits [7:0]. Fourth byte → WRITE.
- WRITE: `mem_we`=1 with stable addr/data until `mem_ready`; then addr+1, word count+1; count = N → CSUM, else DATA.
- Checksum: 8-bit modulo-256 sum of all data bytes (length bytes excluded).
- CSUM: received byte equals sum → RESP(ACK), else set `err`, RESP(NAK).
- RESP: wait `tx_busy`=0, pulse `tx_start` one cycle (with `done` if ACK) → WAITLOW.
- WAITLOW: remain until `prog`=0 → IDLE; ignore `rx_valid`.
- `rx_valid` in WRITE (overrun): byte dropped, `err` set, RESP(NAK) after write completes.
- Timeout: in LEN0/LEN1/DATA/CSUM, idle counter reaches TIMEOUT_CYC → `err`, RESP(NAK). Counter resets on each `rx_valid`.
- `prog` falls in any non-IDLE state other than WAITLOW: abort to IDLE next cycle, `mem_we` dropped, `err` set, no response byte.

## Timing
- Reset: all outputs 0; state IDLE; `tx_data` 0x00.
- `core_hold` rises the cycle after `prog` rising edge is sampled; falls the cycle after IDLE is entered.
- `mem_we` asserts the cycle after the 4th byte's `rx_valid`; minimum write = 1 cycle when `mem_ready` already high.
- `mem_addr` wraps never; max address 2^ADDR_W−1 guaranteed by the length check.
- Simultaneous `prog` fall and `mem_ready`: abort wins; the write is considered not performed.
- Timeout comparison is ≥ TIMEOUT_CYC; counter saturates.

## Configuration
- `LOADER_CSUM_EN` defined: CSUM state present, checksum byte expected and checked as above.
- Not defined: no checksum byte; after last word (or N = 0) go directly to RESP(ACK); checksum logic removed.

## Test plan
- N=2, bytes 0x13,0x00,0x00,0x00,0xB7,0x02,0x00,0x00, csum 0xCC, `mem_ready`=1 → writes addr 0=0x00000013, addr 1=0x000002B7; `tx_data`=0x06, `done` pulse, `err`=0.
- Same stream, csum 0x00 → both writes occur, `tx_data`=0x15, `err`=1, `done` never pulses.
- `mem_ready` held low 20 cycles on first write → `mem_we`, addr 0, data stable 20 cycles; addr 1 only after acceptance.
- N=0x1001 with ADDR_W=12 → no writes, NAK, `err`=1, `core_hold` until `prog` low.
- Stop stream after 3 data bytes, TIMEOUT_CYC=50 → NAK 50 cycles after last byte; drop `prog` mid-DATA in another run → IDLE, `core_hold`=0, no tx.
- Assert `Rst` mid-WRITE → all outputs 0 immediately, state IDLE; new `prog` edge starts cleanly at addr 0.
